acc_stack: RTL
==============

ACC_STACK -- requirements
Module: acc_stack

Interface
REQ-001 Parameter WIDTH, default 8, accumulator and data-input width in bits (>=2).
REQ-002 Parameter IMM_W, default 4, immediate width in bits (1..WIDTH).
REQ-003 Parameter DEPTH, default 4, save-stack entries (>=1).
REQ-004 clk  in  1  single clock, all state changes on rising edge.
REQ-005 CLB  in  1  reset, asynchronous, active-low.
REQ-006 op  in  3  operation: 000 hold, 001 load, 010 push, 011 pop, 100 clear, 101 shl, 110 shr, 111 reserved.
REQ-007 sel_acc  in  2  load source: 00 alu_in, 01 reg_in, 10 imm zero-extended, 11 imm sign-extended.
REQ-008 alu_in  in  WIDTH  ALU result.
REQ-009 reg_in  in  WIDTH  register-file read data.
REQ-010 imm  in  IMM_W  instruction immediate.
REQ-011 acc_out  out  WIDTH  accumulator register value.
REQ-012 zero  out  1  high when acc_out == 0 (combinational from acc register).
REQ-013 count  out  clog2(DEPTH+1)  number of occupied stack entries.
REQ-014 full  out  1  count == DEPTH; empty  out  1  count == 0.
REQ-015 err  out  1  registered one-cycle pulse on an illegal operation.
REQ-016 shift_out  out  1  registered bit shifted out by last shl/shr.

Function
REQ-017 All ops SHALL take effect at the rising clk edge on which they are sampled; acc_out, count, err, shift_out reflect the op one cycle later (latency 1).
REQ-018 op 000 SHALL leave all state unchanged; err low.
REQ-019 op 001 SHALL load acc from the sel_acc source; sign extension replicates imm[IMM_W-1].
REQ-020 op 010 with count < DEPTH SHALL write acc into stack[count], increment count, leave acc unchanged.
REQ-021 op 011 with count > 0 SHALL load acc from stack[count-1] and decrement count (LIFO).
REQ-022 op 100 SHALL set acc to 0; stack and count unchanged.
REQ-023 op 010 when full SHALL change no state and pulse err for one cycle.
REQ-024 op 011 when empty SHALL change no state and pulse err for one cycle.
REQ-025 op 111 SHALL change no state and pulse err for one cycle.
REQ-026 err SHALL be low in every cycle following a legal op; back-to-back illegal ops keep err high continuously.
REQ-027 A push of acc and a subsequent pop SHALL return the exact WIDTH-bit value pushed, with no truncation.
REQ-028 shift_out SHALL hold its value on all ops other than shl/shr.

Reset
REQ-029 CLB low SHALL immediately force acc_out=0, count=0, err=0, shift_out=0, independent of clk.
REQ-030 Stack storage is not reset; its contents are unobservable while count=0.
REQ-031 Reset asserted mid-sequence SHALL discard any op in flight; first op honoured is the one sampled at the first rising edge with CLB high.

Configuration
REQ-032 Macro ACC_SHIFT_EN, when defined, SHALL enable op 101 (acc <= acc<<1, LSB 0, shift_out <= old MSB) and op 110 (acc <= acc>>1 logical, MSB 0, shift_out <= old LSB).
REQ-033 Without ACC_SHIFT_EN, ops 101 and 110 SHALL behave as op 111 (no state change, err pulse) and shift_out SHALL be constant 0.

Verification (WIDTH=8, IMM_W=4, DEPTH=4)
REQ-034 CLB low with acc=0x5A, count=2 -> acc_out=0x00, count=0, empty=1, zero=1 before next clk edge.
REQ-035 op=001 sel=11 imm=0xA -> acc_out=0xFA; sel=10 imm=0xA -> 0x0A; sel=00 alu_in=0x33 -> 0x33.
REQ-036 load 0x11,push,load 0x22,push,load 0x33,push,load 0x44,push -> full=1,count=4; fifth push -> err one cycle, count=4; four pops -> acc 0x44,0x33,0x22,0x11, empty=1.
REQ-037 empty stack, op=011 twice then op=000 -> err high two cycles then low, acc unchanged.
REQ-038 ACC_SHIFT_EN defined, acc=0x81, op=101 -> acc=0x02, shift_out=1; op=110 -> acc=0x01, shift_out=0; macro undefined, op=101 -> acc unchanged, err pulse, shift_out=0.
REQ-039 CLB pulsed low between push and pop of 0x7E -> subsequent pop gives err pulse, acc_out=0x00.

Source files
------------

// File: rtl/acc_stack.sv
// -----------------------------------------------------------------------------
// acc_stack
//   Accumulator register backed by a small LIFO save stack. The accumulator
//   can be loaded from the ALU result, the register file, or a zero/sign
//   extended immediate. It can be pushed to and popped from the stack,
//   cleared, and optionally shifted one bit left or right.
//   Illegal operations raise a one-cycle registered error pulse:
//     - push when the stack is full,
//     - pop when the stack is empty,
//     - the reserved opcode,
//     - the shift opcodes when shifting is not built in.
//
// Build option:
//   ACC_SHIFT_EN  when defined, enables op 101 (shl) and op 110 (shr).
//                 When undefined, both opcodes are treated as illegal and
//                 shift_out stays at 0.
//
// Parameters:
//   WIDTH  accumulator / data width in bits (>= 2)
//   IMM_W  immediate width in bits (1..WIDTH)
//   DEPTH  number of save-stack entries (>= 1)
//
// Ports:
//   clk        in   rising-edge clock
//   CLB        in   asynchronous active-low reset
//   op         in   3-bit opcode:
//                     000 hold, 001 load, 010 push, 011 pop,
//                     100 clear, 101 shl, 110 shr, 111 reserved
//   sel_acc    in   load source:
//                     00 alu_in, 01 reg_in,
//                     10 imm zero-extended, 11 imm sign-extended
//   alu_in     in   ALU result
//   reg_in     in   register-file read data
//   imm        in   instruction immediate
//   acc_out    out  accumulator register
//   zero       out  accumulator equals zero
//   count      out  occupied stack entries
//   full       out  count == DEPTH
//   empty      out  count == 0
//   err        out  registered one-cycle illegal-op pulse
//   shift_out  out  registered bit shifted out by the last shl/shr
// -----------------------------------------------------------------------------
module acc_stack #(
    parameter int WIDTH = 8,
    parameter int IMM_W = 4,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             CLB,
    input  logic [2:0]       op,
    input  logic [1:0]       sel_acc,
    input  logic [WIDTH-1:0] alu_in,
    input  logic [WIDTH-1:0] reg_in,
    input  logic [IMM_W-1:0] imm,
    output logic [WIDTH-1:0] acc_out,
    output logic             zero,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             err,
    output logic             shift_out
);

    typedef enum logic [2:0] {
        OP_HOLD  = 3'b000,
        OP_LOAD  = 3'b001,
        OP_PUSH  = 3'b010,
        OP_POP   = 3'b011,
        OP_CLEAR = 3'b100,
        OP_SHL   = 3'b101,
        OP_SHR   = 3'b110,
        OP_RSVD  = 3'b111
    } op_e;

    // Immediate extension. Building the word as {fill, imm} and keeping the
    // low WIDTH bits stays legal even when IMM_W == WIDTH (no zero-width
    // replication).
    function automatic logic [WIDTH-1:0] ext_imm(
        input logic [IMM_W-1:0] value,
        input logic             sext
    );
        logic                     fill;
        logic [WIDTH+IMM_W-1:0]   wide;
        fill = sext & value[IMM_W-1];
        wide = {{WIDTH{fill}}, value};
        return wide[WIDTH-1:0];
    endfunction

    // Architectural state
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             shift_q, shift_d;

    // Stack storage. Deliberately not reset: entries at or above the count
    // are never observable.
    logic [WIDTH-1:0] stack_q [DEPTH];

    // Decode helpers
    op_e              op_s;
    logic             full_s;
    logic             empty_s;
    logic             push_en_s;
    logic [WIDTH-1:0] load_src_s;
    logic [WIDTH-1:0] top_s;

    assign op_s    = op_e'(op);
    assign full_s  = (cnt_q == CW'(DEPTH));
    assign empty_s = (cnt_q == {CW{1'b0}});

    // Load source selection
    always_comb begin
        load_src_s = alu_in;
        case (sel_acc)
            2'b00:   load_src_s = alu_in;
            2'b01:   load_src_s = reg_in;
            2'b10:   load_src_s = ext_imm(imm, 1'b0);
            2'b11:   load_src_s = ext_imm(imm, 1'b1);
            default: load_src_s = alu_in;
        endcase
    end

    // Top-of-stack read: entry count-1. A compare loop avoids index-width
    // mismatches between the count and the array range.
    always_comb begin
        top_s = stack_q[0];
        for (int i = 0; i < DEPTH; i++) begin
            top_s = (cnt_q == CW'(i + 1)) ? stack_q[i] : top_s;
        end
    end

    // Next-state decode for accumulator, count, error and shift bit
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        shift_d   = shift_q;
        push_en_s = 1'b0;
        case (op_s)
            OP_HOLD: begin
                acc_d = acc_q;
            end
            OP_LOAD: begin
                acc_d = load_src_s;
            end
            OP_PUSH: begin
                if (!full_s) begin
                    push_en_s = 1'b1;
                    cnt_d     = cnt_q + CW'(1'b1);
                end else begin
                    err_d = 1'b1;
                end
            end
            OP_POP: begin
                if (!empty_s) begin
                    acc_d = top_s;
                    cnt_d = cnt_q - CW'(1'b1);
                end else begin
                    err_d = 1'b1;
                end
            end
            OP_CLEAR: begin
                acc_d = {WIDTH{1'b0}};
            end
`ifdef ACC_SHIFT_EN
            OP_SHL: begin
                acc_d   = {acc_q[WIDTH-2:0], 1'b0};
                shift_d = acc_q[WIDTH-1];
            end
            OP_SHR: begin
                acc_d   = {1'b0, acc_q[WIDTH-1:1]};
                shift_d = acc_q[0];
            end
`else
            OP_SHL: begin
                err_d = 1'b1;
            end
            OP_SHR: begin
                err_d = 1'b1;
            end
`endif
            OP_RSVD: begin
                err_d = 1'b1;
            end
            default: begin
                err_d = 1'b1;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            acc_q   <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            err_q   <= 1'b0;
            shift_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            shift_q <= shift_d;
        end
    end

    // Stack write: the current accumulator goes into entry count on a
    // legal push
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push_en_s && (cnt_q == CW'(i))) begin
                stack_q[i] <= acc_q;
            end
        end
    end

    assign acc_out   = acc_q;
    assign zero      = (acc_q == {WIDTH{1'b0}});
    assign count     = cnt_q;
    assign full      = full_s;
    assign empty     = empty_s;
    assign err       = err_q;
    assign shift_out = shift_q;

endmodule
